// File: rtl/tri_pixel_sched_pkg.sv
// Fixed-point and triangle types shared by the per-pixel triangle scheduler.
// fixed_pkg holds the Q16.16 scalar type; tri_pkg builds the triangle record on it.
package fixed_pkg;
  typedef logic signed [31:0] q16_16_t;
  localparam int FRAC_BITS = 16;
endpackage

package tri_pkg;
  import fixed_pkg::*;

  typedef logic [11:0] color_t;

  typedef struct packed {
    q16_16_t ax;
    q16_16_t ay;
    q16_16_t az;
    q16_16_t bx;
    q16_16_t by;
    q16_16_t bz;
    q16_16_t cx;
    q16_16_t cy;
    q16_16_t cz;
    color_t  a_color;
    color_t  b_color;
    color_t  c_color;
  } triangle_t;

  localparam q16_16_t Z_FAR = 32'sh7FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } sched_state_e;
endpackage

// File: rtl/tri_pixel_sched_depth.sv
// Combinational nearest-hit select: a covered sample replaces the running best
// only when strictly closer, so earlier (lower-index) triangles win depth ties.
module tri_depth_select
  import fixed_pkg::*;
  import tri_pkg::*;
(
  input  logic    inside_i,
  input  q16_16_t z_i,
  input  color_t  color_i,
  input  q16_16_t best_z_i,
  input  color_t  best_color_i,
  input  logic    best_hit_i,
  output logic    take_o,
  output q16_16_t sel_z_o,
  output color_t  sel_color_o,
  output logic    sel_hit_o
);

  always_comb begin
    take_o      = inside_i && (z_i < best_z_i);
    sel_z_o     = take_o ? z_i : best_z_i;
    sel_color_o = take_o ? color_i : best_color_i;
    sel_hit_o   = best_hit_i | take_o;
  end

endmodule

// File: rtl/tri_pixel_sched.sv
// Per-pixel scheduler sharing one triangle evaluator across a triangle RAM.
// Optional perf counters (perf_pixels/perf_stall/perf_clr) under TRI_PIXEL_SCHED_PERF_EN.
module tri_pixel_sched
  import fixed_pkg::*;
  import tri_pkg::*;
#(
  parameter int     CORDW    = 10,
  parameter int     MAX_TRIS = 64,
  parameter color_t BG_COLOR = 12'h008,
  localparam int    AW       = $clog2(MAX_TRIS)
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic [AW:0]      tri_count,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [CORDW-1:0] pix_x,
  input  logic [CORDW-1:0] pix_y,
  output logic             tri_rd_en,
  output logic [AW-1:0]    tri_rd_addr,
  input  triangle_t        tri_rd_data,
  output triangle_t        eval_tri,
  output logic [31:0]      eval_px,
  output logic [31:0]      eval_py,
  input  logic             eval_inside,
  input  q16_16_t          eval_z,
  input  color_t           eval_color,
  output logic             out_valid,
  input  logic             out_ready,
  output color_t           out_color,
  output logic             out_hit,
  output q16_16_t          out_z
`ifdef TRI_PIXEL_SCHED_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [31:0]      perf_pixels,
  output logic [31:0]      perf_stall
`endif
);

  localparam logic [AW:0] MAX_CNT = (AW + 1)'(MAX_TRIS);

  sched_state_e     state_q, state_d;
  logic [CORDW-1:0] x_q, x_d;
  logic [CORDW-1:0] y_q, y_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW:0]      next_addr_q, next_addr_d;
  logic             rd_pending_q, rd_pending_d;
  q16_16_t          best_z_q, best_z_d;
  color_t           best_color_q, best_color_d;
  logic             hit_q, hit_d;

  logic [AW:0]      cnt_in;
  logic             take;
  q16_16_t          sel_z;
  color_t           sel_color;
  logic             sel_hit;

  assign cnt_in = (tri_count > MAX_CNT) ? MAX_CNT : tri_count;

  // The RAM output register is the pipeline stage feeding the evaluator,
  // which keeps throughput at one triangle per cycle with no extra latency.
  assign eval_tri = tri_rd_data;
  assign eval_px  = 32'(x_q) << FRAC_BITS;
  assign eval_py  = 32'(y_q) << FRAC_BITS;

  assign out_color = best_color_q;
  assign out_hit   = hit_q;
  assign out_z     = best_z_q;

  tri_depth_select u_depth (
    .inside_i     (eval_inside),
    .z_i          (eval_z),
    .color_i      (eval_color),
    .best_z_i     (best_z_q),
    .best_color_i (best_color_q),
    .best_hit_i   (hit_q),
    .take_o       (take),
    .sel_z_o      (sel_z),
    .sel_color_o  (sel_color),
    .sel_hit_o    (sel_hit)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    next_addr_d  = next_addr_q;
    rd_pending_d = 1'b0;
    best_z_d     = best_z_q;
    best_color_d = best_color_q;
    hit_d        = hit_q;
    pix_ready    = 1'b0;
    tri_rd_en    = 1'b0;
    tri_rd_addr  = '0;
    out_valid    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          x_d          = pix_x;
          y_d          = pix_y;
          cnt_d        = cnt_in;
          best_z_d     = Z_FAR;
          best_color_d = BG_COLOR;
          hit_d        = 1'b0;
          if (cnt_in == '0) begin
            state_d = ST_DONE;
          end else begin
            tri_rd_en    = 1'b1;
            rd_pending_d = 1'b1;
            next_addr_d  = (AW + 1)'(1);
            state_d      = ST_STREAM;
          end
        end
      end

      ST_STREAM: begin
        if (next_addr_q < cnt_q) begin
          tri_rd_en    = 1'b1;
          tri_rd_addr  = next_addr_q[AW-1:0];
          next_addr_d  = next_addr_q + (AW + 1)'(1);
          rd_pending_d = 1'b1;
        end
        if (rd_pending_q) begin
          best_z_d     = sel_z;
          best_color_d = sel_color;
          hit_d        = sel_hit;
        end
        // Final merge happens this cycle once no further read is outstanding.
        if (rd_pending_q && !tri_rd_en) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      next_addr_q  <= '0;
      rd_pending_q <= 1'b0;
      best_z_q     <= Z_FAR;
      best_color_q <= BG_COLOR;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      next_addr_q  <= next_addr_d;
      rd_pending_q <= rd_pending_d;
      best_z_q     <= best_z_d;
      best_color_q <= best_color_d;
      hit_q        <= hit_d;
    end
  end

`ifdef TRI_PIXEL_SCHED_PERF_EN
  logic [31:0] perf_pixels_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      perf_pixels_q <= '0;
      perf_stall_q  <= '0;
    end else if (perf_clr) begin
      perf_pixels_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (out_valid && out_ready) perf_pixels_q <= perf_pixels_q + 32'd1;
      if (out_valid && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_pixels = perf_pixels_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
